// File: rtl/sd_model_axi_reader.sv
// sd_model_axi_reader: AXI4 read master streaming 512-byte DDR sectors out as 16-bit halfwords.
// Define SD_RD_PREFETCH_EN for a ping-pong beat buffer that fetches ahead of the unpacker.
module sd_model_axi_reader #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [31:0]           sec_num,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   model_arid,
    output logic [ADDR_WIDTH-1:0] model_araddr,
    output logic [7:0]            model_arlen,
    output logic [2:0]            model_arsize,
    output logic [1:0]            model_arburst,
    output logic                  model_arlock,
    output logic [3:0]            model_arcache,
    output logic [2:0]            model_arprot,
    output logic                  model_arvalid,
    input  logic                  model_arready,
    input  logic [DATA_WIDTH-1:0] model_rdata,
    input  logic [1:0]            model_rresp,
    input  logic                  model_rlast,
    input  logic                  model_rvalid,
    output logic                  model_rready,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    typedef enum logic [1:0] {IDLE, AR, DATA, FIN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           sec_q, sec_d;
    logic [3:0]            beat_q, beat_d, hw_q, hw_d;
    logic                  err_q, err_d, last_q, last_d;
    logic [DATA_WIDTH-1:0] hd_q, hd_d;
    logic                  hd_v_q, hd_v_d;
    logic                  rx, pop, hw_end, hd_free, last_beat, drain;
    assign model_arid    = '0;
    assign model_arlen   = 8'd15;
    assign model_arsize  = 3'd5;
    assign model_arburst = 2'b01;
    assign model_arlock  = 1'b0;
    assign model_arcache = 4'b0011;
    assign model_arprot  = 3'd0;
    assign model_araddr  = addr_q;
    assign model_arvalid = state_q == AR;
    assign busy          = state_q == AR || state_q == DATA;
    assign done          = state_q == FIN;
    assign err           = err_q;
    assign out_valid     = hd_v_q;
    assign out_data      = hd_q[15:0];
    assign rx            = model_rvalid & model_rready;
    assign pop           = hd_v_q & out_ready;
    assign hw_end        = pop & (hw_q == 4'd15);
    assign hd_free       = ~hd_v_q | hw_end;
    assign last_beat     = rx & (beat_q == 4'd15);
`ifdef SD_RD_PREFETCH_EN
    logic [DATA_WIDTH-1:0] nx_q, nx_d;
    logic                  nx_v_q, nx_v_d;
    assign model_rready = state_q == DATA && !last_q && !nx_v_q;
    assign drain        = hw_end & ~nx_v_q;
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            nx_q   <= '0;
            nx_v_q <= 1'b0;
        end else begin
            nx_q   <= nx_d;
            nx_v_q <= nx_v_d;
        end
    end
    // The second entry only fills while the head is still being unpacked
    always_comb begin
        hd_d   = pop ? hd_q >> 16 : hd_q;
        hd_v_d = ~hd_free;
        nx_d   = nx_q;
        nx_v_d = nx_v_q;
        if (hd_free & nx_v_q) begin
            hd_d   = nx_q;
            hd_v_d = 1'b1;
            nx_v_d = 1'b0;
        end else if (hd_free & rx) begin
            hd_d   = model_rdata;
            hd_v_d = 1'b1;
        end else if (rx) begin
            nx_d   = model_rdata;
            nx_v_d = 1'b1;
        end
    end
`else
    assign model_rready = state_q == DATA && !last_q && !hd_v_q;
    assign drain        = hw_end;
    always_comb begin
        hd_d   = pop ? hd_q >> 16 : hd_q;
        hd_v_d = ~hd_free;
        if (rx) begin
            hd_d   = model_rdata;
            hd_v_d = 1'b1;
        end
    end
`endif
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sec_q   <= '0;
            beat_q  <= '0;
            hw_q    <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            hd_q    <= '0;
            hd_v_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sec_q   <= sec_d;
            beat_q  <= beat_d;
            hw_q    <= hw_d;
            err_q   <= err_d;
            last_q  <= last_d;
            hd_q    <= hd_d;
            hd_v_q  <= hd_v_d;
        end
    end
    // last_q marks that beat 15 of the final outstanding burst has been taken
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sec_d   = last_beat ? sec_q - 32'd1 : sec_q;
        beat_d  = rx ? beat_q + 4'd1 : beat_q;
        hw_d    = pop ? hw_q + 4'd1 : hw_q;
        last_d  = last_q;
        err_d   = err_q | (rx & (model_rresp != 2'b00 || model_rlast != (beat_q == 4'd15)));
        case (state_q)
            IDLE: if (start) begin
                state_d = sec_num == 32'd0 ? FIN : AR;
                addr_d  = src_addr & ~ADDR_WIDTH'(511);
                sec_d   = sec_num;
                beat_d  = 4'd0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
            AR: state_d = model_arready ? DATA : AR;
            DATA: begin
`ifdef SD_RD_PREFETCH_EN
                if (last_beat && sec_q == 32'd1) last_d = 1'b1;
                if (last_beat && sec_q != 32'd1) begin
                    state_d = AR;
                    addr_d  = addr_q + ADDR_WIDTH'(512);
                end
                if (last_q & drain) state_d = FIN;
`else
                if (last_beat) last_d = 1'b1;
                if (last_q & drain) begin
                    state_d = sec_q == 32'd0 ? FIN : AR;
                    addr_d  = addr_q + ADDR_WIDTH'(512);
                    last_d  = 1'b0;
                end
`endif
            end
            FIN: state_d = IDLE;
        endcase
    end
endmodule
